pipeline_sequencer: RTL
=======================

// Module: pipeline_sequencer
// PURPOSE
//  Central stage-enable/flush controller for the 5-stage RV32I pipeline (F,D,X,M,W).
//  Merges the load-use/decode stall request, X-stage control-flow redirects and the
//  M-stage data-memory handshake into per-stage register enables and NOP-injection selects.
//  Also owns the post-reset pipeline drain, memory-timeout halt and stall/flush perf counters.
// PARAMETERS
//  RST_BUBBLES  3   cycles of forced bubbles after reset before fetch starts (1..15)
//  MEM_TIMEOUT  64  max consecutive MEM_WAIT cycles before halting with error (>=2)
//  CNT_W        32  width of each performance counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  stall_req    in   1      D-stage hazard stall (load-use / no-bypass case) from hazard detector
//  redirect_req in   1      X-stage taken branch/JAL/JALR; PC must load target this cycle
//  mem_req      in   1      M-stage insn is LOAD/STORE needing a data-memory access
//  mem_ready    in   1      data memory completes the access this cycle
//  halt_req     in   1      W-stage ECALL/EBREAK retiring
//  pc_en        out  1      PC register load enable
//  fd_en        out  1      F/D register enable
//  dx_en        out  1      D/X, X/M, M/W register enable (one shared freeze)
//  d_nop        out  1      F/D loads NOP (0x00000013) instead of fetched insn
//  x_nop        out  1      D/X loads NOP instead of decoded insn
//  halted       out  1      core halted (sticky until reset)
//  mem_err      out  1      halt caused by MEM_TIMEOUT (sticky until reset)
//  stall_cnt    out  CNT_W  cycles in which stall_req took effect
//  flush_cnt    out  CNT_W  redirects taken
//  wait_cnt     out  CNT_W  cycles spent frozen in MEM_WAIT
// BEHAVIOUR
//  States: DRAIN, RUN, MEM_WAIT, HALT. Reset -> DRAIN, drain counter 0, timeout counter 0,
//   all perf counters 0, halted=0, mem_err=0.
//  DRAIN: pc_en=0, fd_en=dx_en=1, d_nop=x_nop=1; after RST_BUBBLES cycles -> RUN.
//  RUN priority (combinational outputs, same cycle as inputs):
//   1 halt_req           -> all enables 0, -> HALT (W insn retires; nothing younger commits)
//   2 mem_req&!mem_ready -> pc_en=fd_en=dx_en=0, no NOPs, -> MEM_WAIT, timeout cnt=1
//   3 redirect_req       -> pc_en=fd_en=dx_en=1, d_nop=x_nop=1, flush_cnt++ (beats stall_req)
//   4 stall_req          -> pc_en=fd_en=0, dx_en=1, x_nop=1, stall_cnt++
//   5 else               -> all enables 1, NOPs 0
//  mem_req&mem_ready in RUN = zero-wait access: no freeze, fall through to 3..5.
//  MEM_WAIT: all enables 0, NOPs 0, wait_cnt++ each cycle incl. completion cycle.
//   mem_ready=1 -> apply RUN rules 3..5 this cycle (redirect/stall held stable while frozen)
//   and -> RUN. Else timeout cnt++; reaching MEM_TIMEOUT -> HALT, mem_err=1.
//  HALT: all enables 0, NOPs 0, halted=1, counters frozen; exit only by reset.
//  Counters wrap modulo 2^CNT_W; no saturation. halt_req ignored outside RUN/MEM_WAIT-exit.
//  rst_n low mid-operation: immediate async return to DRAIN values; in-flight mem access abandoned.
//  Inputs from stages frozen by this block must be held stable by the datapath; block does not latch them.
// STRUCTURE
//  Shared package rv_pipe_pkg: state encoding (2-bit), NOP_INSN=32'h00000013, opcode localparams.
//  One sub-module: perf_counter (CNT_W, inc, clear-on-reset, value) instantiated 3x.
//  FSM + timeout/drain counters in this module; enable/NOP decode as one combinational block.
// TESTING
//  Reset release, RST_BUBBLES=3: d_nop=x_nop=1,pc_en=0 for cycles 1-3; cycle 4 all enables 1.
//  stall_req 1 cycle in RUN: pc_en=fd_en=0,dx_en=1,x_nop=1; stall_cnt 0->1; next cycle normal.
//  redirect_req & stall_req same cycle: d_nop=x_nop=1, pc_en=1, flush_cnt=1, stall_cnt=0.
//  mem_req=1, mem_ready low 5 cycles then high: 5 frozen cycles + release, wait_cnt=6, back to RUN.
//  MEM_TIMEOUT=4, mem_ready stuck 0: HALT after 4th wait cycle, halted=mem_err=1, enables 0 forever.
//  halt_req in RUN then rst_n pulse mid-HALT: halted clears, state DRAIN, all counters 0.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_sequencer_pkg: sequencer state encoding and RV32I constants shared by the pipeline.
package pipeline_sequencer_pkg;
   typedef enum logic [1:0] {DRAIN = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2, HALT = 2'd3} seq_state_e;
   localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if: hazard/memory requests in, stage enables, NOP selects and perf counters out.
interface pipeline_sequencer_if #(parameter int CNT_W = 32);
   logic             stall_req, redirect_req, mem_req, mem_ready, halt_req;
   logic             pc_en, fd_en, dx_en, d_nop, x_nop, halted, mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
   modport master (
      output stall_req, redirect_req, mem_req, mem_ready, halt_req,
      input  pc_en, fd_en, dx_en, d_nop, x_nop, halted, mem_err, stall_cnt, flush_cnt, wait_cnt
   );
   modport slave (
      input  stall_req, redirect_req, mem_req, mem_ready, halt_req,
      output pc_en, fd_en, dx_en, d_nop, x_nop, halted, mem_err, stall_cnt, flush_cnt, wait_cnt
   );
endinterface

// File: rtl/pipeline_sequencer_perf_counter.sv
// perf_counter: free-running event counter, wraps modulo 2^CNT_W, cleared by reset.
module perf_counter #(parameter int CNT_W = 32) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [CNT_W-1:0] value_o
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) value_o <= '0;
      else        value_o <= value_o + CNT_W'(inc_i);
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stage enables/flushes for the 5-stage pipeline, with post-reset drain,
// data-memory wait/timeout handling and stall/flush/wait performance counters.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int RST_BUBBLES = 3,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic               clk,
   input logic               rst_n,
   pipeline_sequencer_if.slave bus
);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   seq_state_e    state_q;
   logic [3:0]    drain_q;
   logic [TW-1:0] tmo_q;
   logic          halted_q, mem_err_q;
   logic          run_like, halt_go, mem_go, live, redir, stall, go, drain, wait_inc;
   // A MEM_WAIT completion cycle behaves like RUN for redirect/stall/normal decode
   assign run_like = (state_q == RUN) || (state_q == MEM_WAIT && bus.mem_ready);
   assign halt_go  = run_like && bus.halt_req;
   assign mem_go   = (state_q == RUN) && bus.mem_req && !bus.mem_ready && !bus.halt_req;
   assign live     = run_like && !halt_go && !mem_go;
   assign redir    = live && bus.redirect_req;
   assign stall    = live && !bus.redirect_req && bus.stall_req;
   assign go       = live && !bus.redirect_req && !bus.stall_req;
   assign drain    = state_q == DRAIN;
   assign wait_inc = mem_go || state_q == MEM_WAIT;
   assign bus.pc_en   = redir || go;
   assign bus.fd_en   = drain || redir || go;
   assign bus.dx_en   = drain || redir || stall || go;
   assign bus.d_nop   = drain || redir;
   assign bus.x_nop   = drain || redir || stall;
   assign bus.halted  = halted_q;
   assign bus.mem_err = mem_err_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= DRAIN;
         drain_q   <= '0;
         tmo_q     <= '0;
         halted_q  <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         case (state_q)
            DRAIN: begin
               drain_q <= drain_q + 4'd1;
               if (drain_q == 4'(RST_BUBBLES - 1)) state_q <= RUN;
            end
            RUN:
               if (halt_go) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end else if (mem_go) begin
                  state_q <= MEM_WAIT;
                  tmo_q   <= TW'(1);
               end
            MEM_WAIT:
               if (bus.mem_ready) begin
                  state_q  <= bus.halt_req ? HALT : RUN;
                  halted_q <= bus.halt_req;
               end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
                  state_q   <= HALT;
                  halted_q  <= 1'b1;
                  mem_err_q <= 1'b1;
               end else tmo_q <= tmo_q + TW'(1);
            default: ;
         endcase
      end
   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc_i(stall),    .value_o(bus.stall_cnt));
   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc_i(redir),    .value_o(bus.flush_cnt));
   perf_counter #(.CNT_W(CNT_W)) u_wait_cnt  (.clk(clk), .rst_n(rst_n), .inc_i(wait_inc), .value_o(bus.wait_cnt));
endmodule
